fetch_queue: RTL
================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning address/instruction width.
REQ-002 SHALL have parameter DEPTH, default 4, meaning queue entries; power of two, >=2.
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch address.
REQ-004 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port redirect_valid  input  1  branch/jump redirect request.
REQ-007 SHALL have port redirect_pc  input  XLEN  redirect target address.
REQ-008 SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-009 SHALL have port imem_req_ready  input  1  memory accepts request.
REQ-010 SHALL have port imem_req_addr  output  XLEN  fetch address.
REQ-011 SHALL have port imem_rsp_valid  input  1  in-order response valid, latency >=1 cycle.
REQ-012 SHALL have port imem_rsp_data  input  XLEN  fetched instruction.
REQ-013 SHALL have port out_valid  output  1  head entry valid to decode.
REQ-014 SHALL have port out_ready  input  1  decode accepts head entry.
REQ-015 SHALL have port out_pc  output  XLEN  head entry PC.
REQ-016 SHALL have port out_instr  output  XLEN  head entry instruction.
REQ-017 SHALL have port occupancy  output  $clog2(DEPTH)+1  entries held.

Function
REQ-018 SHALL hold fetch_pc (next request address), rsp_pc (PC of next accepted response), inflight (requests handshaken, response not yet received), drop_cnt (inflight responses to discard).
REQ-019 SHALL drive imem_req_valid = rst_n && !redirect_valid && (occupancy + inflight < DEPTH); imem_req_addr = fetch_pc.
REQ-020 SHALL, on imem_req_valid && imem_req_ready, advance fetch_pc by 4 (wrap mod 2^XLEN) and increment inflight.
REQ-021 SHALL, on imem_rsp_valid with drop_cnt==0, push {rsp_pc, imem_rsp_data} at tail, advance rsp_pc by 4, decrement inflight.
REQ-022 SHALL, on imem_rsp_valid with drop_cnt>0, discard data, decrement drop_cnt and inflight; rsp_pc unchanged.
REQ-023 SHALL ignore imem_rsp_valid when inflight==0 (protocol error, no state change).
REQ-024 SHALL be show-ahead: out_valid = (occupancy!=0) && !redirect_valid; out_pc/out_instr = head entry combinationally.
REQ-025 SHALL pop head on out_valid && out_ready; push and pop in the same cycle leave occupancy unchanged.
REQ-026 SHALL never overflow: credit rule (REQ-019) guarantees space for every non-dropped response.
REQ-027 SHALL, on redirect_valid, next cycle: occupancy=0, fetch_pc=rsp_pc=redirect_pc, drop_cnt = inflight minus one if a response arrives that cycle, else inflight (all same-cycle responses dropped, same-cycle pops ignored, no request issued).
REQ-028 SHALL resume fetching at redirect_pc the cycle after redirect, even while drop_cnt>0.
REQ-029 SHALL, on back-to-back redirects, apply only the latest target; drop_cnt recomputed each cycle per REQ-027.
REQ-030 SHALL keep inflight <= DEPTH; counters sized $clog2(DEPTH)+1.

Reset
REQ-031 SHALL, while rst_n==0 at a clock edge, set fetch_pc=rsp_pc=RESET_PC, occupancy=inflight=drop_cnt=0, head/tail pointers 0.
REQ-032 SHALL hold imem_req_valid=0 and out_valid=0 during reset; out_pc/out_instr don't-care.
REQ-033 SHALL require the memory to discard outstanding requests on reset mid-operation; the queue retains no pre-reset state.

Verification
REQ-034 Reset, 1-cycle memory, out_ready=1 -> out_pc sequence 0x0,0x4,0x8,... one per cycle after fill, no gaps.
REQ-035 out_ready=0, DEPTH=4, latency 3 -> exactly 4 requests issued, occupancy reaches 4, imem_req_valid stays 0 until a pop.
REQ-036 3 requests inflight, redirect_valid to 0x100 -> 3 responses dropped, first out_pc=0x100, next 0x104.
REQ-037 redirect coinciding with a response and out_ready=1 -> response dropped, no pop counted, drop_cnt=inflight-1.
REQ-038 fetch_pc=0xFFFF_FFFC, XLEN=32 -> next request address 0x0000_0000.
REQ-039 rst_n low mid-stream with occupancy 3 -> next cycle occupancy=0, imem_req_addr=RESET_PC after release.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues sequential fetch requests, buffers in-order responses, presents the head show-ahead to decode.
// A redirect flushes the queue and discards responses still in flight from the old path.
module fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   redirect_valid,
    input  logic [XLEN-1:0]        redirect_pc,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [XLEN-1:0]        imem_req_addr,
    input  logic                   imem_rsp_valid,
    input  logic [XLEN-1:0]        imem_rsp_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        out_pc,
    output logic [XLEN-1:0]        out_instr,
    output logic [$clog2(DEPTH):0] occupancy
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_rsp_pc;
    logic [CW-1:0]   r_inflight;
    logic [CW-1:0]   r_drop_cnt;
    logic [CW-1:0]   r_occ;
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [XLEN-1:0] r_pc_q    [DEPTH];
    logic [XLEN-1:0] r_instr_q [DEPTH];

    logic        w_req_fire;
    logic        w_rsp_take;
    logic        w_push;
    logic        w_pop;
    logic [CW:0] w_credit_used;

    // Every outstanding request owns a queue slot, so a non-dropped response always fits.
    assign w_credit_used  = {1'b0, r_occ} + {1'b0, r_inflight};
    assign imem_req_valid = rst_n && !redirect_valid && (w_credit_used < LIMIT);
    assign imem_req_addr  = r_fetch_pc;

    assign w_req_fire = imem_req_valid && imem_req_ready;
    assign w_rsp_take = imem_rsp_valid && (r_inflight != '0);
    assign w_push     = w_rsp_take && (r_drop_cnt == '0) && !redirect_valid;
    assign w_pop      = out_valid && out_ready;

    assign out_valid = rst_n && (r_occ != '0) && !redirect_valid;
    assign out_pc    = r_pc_q[r_head];
    assign out_instr = r_instr_q[r_head];
    assign occupancy = r_occ;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
            r_rsp_pc   <= RESET_PC;
            r_inflight <= '0;
            r_drop_cnt <= '0;
            r_occ      <= '0;
            r_head     <= '0;
            r_tail     <= '0;
        end else begin
            case ({w_req_fire, w_rsp_take})
                2'b10:   r_inflight <= r_inflight + CW'(1);
                2'b01:   r_inflight <= r_inflight - CW'(1);
                default: r_inflight <= r_inflight;
            endcase

            if (redirect_valid) begin
                // Whatever is still outstanding after this cycle belongs to the old path.
                r_fetch_pc <= redirect_pc;
                r_rsp_pc   <= redirect_pc;
                r_occ      <= '0;
                r_head     <= '0;
                r_tail     <= '0;
                r_drop_cnt <= r_inflight - (w_rsp_take ? CW'(1) : CW'(0));
            end else begin
                if (w_req_fire)
                    r_fetch_pc <= r_fetch_pc + XLEN'(4);
                if (w_push) begin
                    r_rsp_pc <= r_rsp_pc + XLEN'(4);
                    r_tail   <= r_tail + 1'b1;
                end
                if (w_pop)
                    r_head <= r_head + 1'b1;
                case ({w_push, w_pop})
                    2'b10:   r_occ <= r_occ + CW'(1);
                    2'b01:   r_occ <= r_occ - CW'(1);
                    default: r_occ <= r_occ;
                endcase
                if (w_rsp_take && (r_drop_cnt != '0))
                    r_drop_cnt <= r_drop_cnt - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_q[r_tail]    <= r_rsp_pc;
            r_instr_q[r_tail] <= imem_rsp_data;
        end
    end
endmodule
